// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: runs ahead of IF/OF, buffering {pc, instr} pairs
// fetched over a single-outstanding req/ack memory handshake, with branch flush.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IsBranchTaken,
    input  logic [31:0] BranchPC,
    input  logic        Stall,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ack,
    input  logic [31:0] Imem_Data,
    output logic        Valid,
    output logic [31:0] Instruction,
    output logic [31:0] pc_current
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_e                  state_q, state_d;
    entry_t [DEPTH-1:0]      mem_q, mem_d;
    logic   [AW-1:0]         head_q, head_d, tail_q, tail_d;
    logic   [CW-1:0]         count_q, count_d;
    logic   [31:0]           fpc_q, fpc_d, addr_q, addr_d;
    logic                    req_q, req_d;

    logic                    flush, pop, push, room;
    logic   [31:0]           bpc;

    always_comb begin
        flush = IsBranchTaken;
        bpc   = BranchPC & ~32'h3;
        pop   = (count_q != '0) && !Stall;
        push  = (state_q == REQ) && Imem_Ack && !flush;

        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        if (push) begin
            mem_d[tail_q] = '{pc: addr_q, instr: Imem_Data};
            tail_d        = tail_q + AW'(1);
        end
        // A flush never coincides with a push, so tail_q is the post-edge tail.
        if (flush) begin
            count_d = '0;
            head_d  = tail_q;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (pop) head_d = head_q + AW'(1);
        end
        room = (count_d < CW'(DEPTH));

        state_d = state_q;
        fpc_d   = fpc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (flush) fpc_d = bpc;
                if (room) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = fpc_d;
                end
            end
            REQ: begin
                if (flush) begin
                    fpc_d = bpc;
                    if (Imem_Ack) addr_d  = bpc;
                    else          state_d = DROP;
                end else if (Imem_Ack) begin
                    fpc_d = addr_q + 32'd4;
                    if (room) begin
                        addr_d = fpc_d;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            DROP: begin
                // Buffer is empty here (flushed, no pushes), so a new request always fits.
                if (flush) fpc_d = bpc;
                if (Imem_Ack) begin
                    state_d = REQ;
                    addr_d  = fpc_d;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fpc_q   <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    assign Imem_Req    = req_q;
    assign Imem_Addr   = addr_q;
    assign Valid       = (count_q != '0);
    assign Instruction = mem_q[head_q].instr;
    assign pc_current  = mem_q[head_q].pc;

endmodule
